// File: rtl/ls368_bus_receiver.sv
// ls368_bus_receiver
//   Receive end of a hex inverting three-state line driver (group 1: 4 lines,
//   group 2: 2 lines, each with an active-low group enable). Every incoming
//   line is synchronised into the CLK domain, re-inverted to true polarity and
//   deglitched per group. Each group presents a held data word, a valid flag,
//   a one-cycle update strobe and a float flag (transmitter disabled).
//
// Ports
//   CLK        system clock, rising edge
//   _CLR       asynchronous active-low reset
//   _1G, _1Y   group-1 enable (active-low) and inverted data lines [3:0]
//   _2G, _2Y   group-2 enable (active-low) and inverted data lines [1:0]
//   D1, D2     accepted data, true polarity
//   V1, V2     group holds an accepted word
//   STB1, STB2 one-cycle pulse when the accepted word changes
//   FLOAT1/2   group transmitter disabled (bus high-Z)
//
// Parameters
//   STABLE_CYCLES  synced samples a word must hold before acceptance (1..15)

module ls368_bus_receiver #(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       _CLR,
    input  logic       _1G,
    input  logic [3:0] _1Y,
    input  logic       _2G,
    input  logic [1:0] _2Y,
    output logic [3:0] D1,
    output logic [1:0] D2,
    output logic       V1,
    output logic       V2,
    output logic       STB1,
    output logic       STB2,
    output logic       FLOAT1,
    output logic       FLOAT2
);

    // The two groups share no state; each instance owns its own
    // synchroniser, sample register and counter.
    ls368_group #(
        .W             (4),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_grp1 (
        .gclk   (CLK),
        .grst_n (_CLR),
        .g_n    (_1G),
        .y      (_1Y),
        .d      (D1),
        .v      (V1),
        .stb    (STB1),
        .flt    (FLOAT1)
    );

    ls368_group #(
        .W             (2),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_grp2 (
        .gclk   (CLK),
        .grst_n (_CLR),
        .g_n    (_2G),
        .y      (_2Y),
        .d      (D2),
        .v      (V2),
        .stb    (STB2),
        .flt    (FLOAT2)
    );

endmodule

// ls368_group
//   One receiver group: 2-flop synchroniser on enable and data, then a
//   DISABLED / SETTLE / VALID deglitch FSM with registered outputs.
//
// Ports
//   gclk, grst_n  clock and asynchronous active-low reset
//   g_n           raw active-low group enable
//   y             raw inverted data lines
//   d, v, stb     accepted word, valid flag, update strobe
//   flt           group disabled (registered, high exactly in DISABLED)

module ls368_group #(
    parameter int W             = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         g_n,
    input  logic [W-1:0] y,
    output logic [W-1:0] d,
    output logic         v,
    output logic         stb,
    output logic         flt
);

    // Synchroniser depth is a fixed property of this revision.
    localparam int SYNC_STAGES = 2;
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SETTLE   = 2'd1,
        VALID    = 2'd2
    } state_t;

    // Shift-register synchronisers; index SYNC_STAGES-1 is the synced output.
    logic [SYNC_STAGES-1:0]        g_pipe;
    logic [SYNC_STAGES-1:0][W-1:0] y_pipe;

    logic         s_g;
    logic [W-1:0] s_w;

    state_t       state;
    logic [W-1:0] sample;
    logic [3:0]   cnt;

    // Reset to 1 = "disabled, lines pulled high", so nothing looks enabled
    // until real samples have propagated through both stages.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            g_pipe <= '1;
            y_pipe <= '1;
        end else begin
            g_pipe <= {g_pipe[SYNC_STAGES-2:0], g_n};
            y_pipe <= {y_pipe[SYNC_STAGES-2:0], y};
        end
    end

    assign s_g = g_pipe[SYNC_STAGES-1];
    assign s_w = ~y_pipe[SYNC_STAGES-1];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state  <= DISABLED;
            sample <= '0;
            cnt    <= '0;
            d      <= '0;
            v      <= 1'b0;
            stb    <= 1'b0;
            flt    <= 1'b1;
        end else begin
            stb <= 1'b0;
            case (state)
                DISABLED: begin
                    if (!s_g) begin
                        state  <= SETTLE;
                        sample <= s_w;
                        cnt    <= '0;
                        flt    <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Disable outranks a data restart on the same sample.
                    if (s_g) begin
                        state <= DISABLED;
                        v     <= 1'b0;
                        cnt   <= '0;
                        flt   <= 1'b1;
                    end else if (s_w != sample) begin
                        sample <= s_w;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= VALID;
                        d     <= sample;
                        v     <= 1'b1;
                        // Re-accepting the word already on d is silent.
                        stb   <= (sample != d);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                VALID: begin
                    if (s_g) begin
                        state <= DISABLED;
                        v     <= 1'b0;
                        flt   <= 1'b1;
                    end else if (s_w != d) begin
                        // Old word stays valid on d while the new one settles.
                        state  <= SETTLE;
                        sample <= s_w;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state <= DISABLED;
                    v     <= 1'b0;
                    cnt   <= '0;
                    flt   <= 1'b1;
                end
            endcase
        end
    end

endmodule
